mips_mem_arbiter: RTL and testbench

Shared-memory arbiter and sequencer for the MIPS32 pipeline's single-port `Memory` array. It lets the instruction-fetch port (read-only) and the load/store data port (read/write) share one synchronous memory port. Each transfer runs through a three-state FSM. Data requests win by priority, and a starvation counter guarantees fetch progress. The block sits between the IF/MEM stage logic and the 1024×32 memory.

---
 rtl/mips_mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_arbiter
// Description : Arbiter and sequencer that lets the instruction-fetch port
//               (read-only) and the load/store data port (read/write) share
//               one single-port synchronous memory. Each transfer runs through
//               IDLE -> ISSUE -> RESP. Data requests normally win, and a
//               starvation counter forces a fetch after STARVE_MAX consecutive
//               data grants made while a fetch was waiting.
//
// Ports       : clk, rst              clock, asynchronous active-high reset
//               i_req/i_addr          fetch request and word address
//               i_ack/i_rdata         fetch acknowledge pulse and read data
//               d_req/d_we/d_addr/
//               d_wdata               data request, store flag, address, data
//               d_ack/d_rdata/d_err   data acknowledge, load data, blocked store
//               mem_en/mem_we/
//               mem_addr/mem_wdata    registered memory strobe and command
//               mem_rdata             memory read data (valid cycle after mem_en)
//               busy                  high while the FSM is not IDLE
//
// Config      : `define MEM_ARB_IPROT_EN to block data stores below IMEM_LIMIT
//               (the store still completes with d_ack, plus d_err).
//
// Revision    : 1.0  initial release
// ============================================================================
module mips_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int IMEM_LIMIT = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

`ifdef MEM_ARB_IPROT_EN
    localparam logic c_iprot_en = 1'b1;
`else
    localparam logic c_iprot_en = 1'b0;
`endif

    localparam logic [3:0]  c_starve_max = 4'(STARVE_MAX);
    localparam logic [AW:0] c_imem_limit = (AW+1)'(IMEM_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic          owner_q,     owner_d;      // 1 = data port owns the transfer
    logic          op_we_q,     op_we_d;      // owner transfer is a store
    logic          blocked_q,   blocked_d;    // store suppressed by protection
    logic [3:0]    starve_cnt_q, starve_cnt_d;
    logic          mem_en_q,    mem_en_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          i_ack_q,     i_ack_d;
    logic          d_ack_q,     d_ack_d;
    logic          d_err_q,     d_err_d;
    logic [DW-1:0] i_rdata_q,   i_rdata_d;
    logic [DW-1:0] d_rdata_q,   d_rdata_d;

    logic w_grant_i;
    logic w_store_blocked;
    logic w_i_capture;
    logic w_d_capture;

    // Fetch wins only when data is absent or the starvation limit is reached.
    assign w_grant_i       = i_req && (!d_req || (starve_cnt_q == c_starve_max));
    assign w_store_blocked = c_iprot_en && d_we && ({1'b0, d_addr} < c_imem_limit);

    // The memory returns data during RESP; it is forwarded in the ack cycle
    // and latched at the end of RESP so the port holds it afterwards.
    assign w_i_capture = (state_q == RESP) && !owner_q;
    assign w_d_capture = (state_q == RESP) && owner_q && !op_we_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        op_we_d      = op_we_q;
        blocked_d    = blocked_q;
        starve_cnt_d = starve_cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = ISSUE;
                    if (w_grant_i) begin
                        owner_d      = 1'b0;
                        op_we_d      = 1'b0;
                        blocked_d    = 1'b0;
                        starve_cnt_d = 4'd0;
                        mem_en_d     = 1'b1;
                        mem_addr_d   = i_addr;
                    end else begin
                        owner_d    = 1'b1;
                        op_we_d    = d_we;
                        blocked_d  = w_store_blocked;
                        mem_en_d   = !w_store_blocked;
                        mem_we_d   = d_we && !w_store_blocked;
                        mem_addr_d = d_addr;
                        if (d_we) begin
                            mem_wdata_d = d_wdata;
                        end
                        // Count only data grants that made a fetch wait.
                        if (i_req) begin
                            starve_cnt_d = (starve_cnt_q >= c_starve_max) ?
                                           c_starve_max : starve_cnt_q + 4'd1;
                        end else begin
                            starve_cnt_d = 4'd0;
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = RESP;
                i_ack_d = !owner_q;
                d_ack_d = owner_q;
                d_err_d = owner_q && blocked_q;
            end
            RESP: begin
                state_d = IDLE;
                if (w_i_capture) begin
                    i_rdata_d = mem_rdata;
                end
                if (w_d_capture) begin
                    d_rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            op_we_q      <= 1'b0;
            blocked_q    <= 1'b0;
            starve_cnt_q <= 4'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            op_we_q      <= op_we_d;
            blocked_q    <= blocked_d;
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign i_rdata   = w_i_capture ? mem_rdata : i_rdata_q;
    assign d_rdata   = w_d_capture ? mem_rdata : d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mem_arbiter
// Description : Self-checking bench for mips_mem_arbiter. A 1024x32 memory
//               with one-cycle read latency sits on the mem_* port; a
//               transaction-level model predicts grant owner, starvation,
//               memory contents and read data.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mips_mem_arbiter;
    localparam int AW         = 10;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
    localparam int IMEM_LIMIT = 256;
`ifdef MEM_ARB_IPROT_EN
    localparam bit c_iprot = 1'b1;
`else
    localparam bit c_iprot = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_ack, d_ack, d_err, mem_en, mem_we, busy;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;

    logic          poke_en;
    logic [AW-1:0] poke_addr;
    logic [DW-1:0] poke_data;

    logic [DW-1:0] mem       [0:1023];
    logic [DW-1:0] model_mem [0:1023];

    int            errors = 0;
    int            checks = 0;
    int            sc;
    logic [DW-1:0] exp_i, exp_d;
    bit            last_gi;

    always #5 clk = ~clk;

    mips_mem_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .IMEM_LIMIT(IMEM_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Synchronous single-port memory; the poke port preloads contents.
    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input logic [DW-1:0] d);
        poke_en   = 1'b1;
        poke_addr = AW'(a);
        poke_data = d;
        model_mem[a] = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        return 32'(k) * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    function automatic logic [AW-1:0] rand_daddr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 31));
        return AW'($urandom_range(240, 319));
    endfunction

    // One arbitration slot starting at a negedge with the FSM in IDLE.
    // Ends at the negedge of the next IDLE cycle with the served request dropped.
    task automatic run_round();
        bit gi, st, blk;
        if (!i_req && !d_req) begin
            @(posedge clk); #1;
            chk("idle_busy", busy, 0);
            chk("idle_acks", {i_ack, d_ack, d_err}, 0);
            @(negedge clk);
            return;
        end
        gi  = i_req && (!d_req || sc == STARVE_MAX);
        st  = !gi && d_we;
        blk = st && c_iprot && (int'(d_addr) < IMEM_LIMIT);
        if (gi)         sc = 0;
        else if (i_req) sc = (sc < STARVE_MAX) ? sc + 1 : STARVE_MAX;
        else            sc = 0;

        @(posedge clk); #1;
        chk("issue_busy", busy, 1);
        chk("issue_mem_en", mem_en, !blk);
        chk("issue_mem_we", mem_we, st && !blk);
        chk("issue_acks", {i_ack, d_ack}, 0);
        if (!blk)       chk("issue_addr", mem_addr, gi ? i_addr : d_addr);
        if (st && !blk) chk("issue_wdata", mem_wdata, d_wdata);

        @(posedge clk); #1;
        if (gi)      exp_i = model_mem[i_addr];
        else if (st) begin
            if (!blk) model_mem[d_addr] = d_wdata;
        end
        else         exp_d = model_mem[d_addr];
        chk("resp_busy", busy, 1);
        chk("resp_mem_en", mem_en, 0);
        chk("resp_mem_we", mem_we, 0);
        chk("resp_mem_addr", mem_addr, 0);
        chk("resp_i_ack", i_ack, gi);
        chk("resp_d_ack", d_ack, !gi);
        chk("resp_d_err", d_err, blk);
        chk("resp_i_rdata", i_rdata, exp_i);
        chk("resp_d_rdata", d_rdata, exp_d);
        last_gi = gi;

        @(posedge clk); #1;
        chk("post_busy", busy, 0);
        chk("post_acks", {i_ack, d_ack, d_err}, 0);
        chk("post_i_rdata", i_rdata, exp_i);
        chk("post_d_rdata", d_rdata, exp_d);
        @(negedge clk);
        if (gi) i_req = 1'b0;
        else    d_req = 1'b0;
    endtask

    initial begin
        bit [9:0] exp_pat;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        poke_en = 0; poke_addr = '0; poke_data = '0;
        sc = 0; exp_i = '0; exp_d = '0; last_gi = 0;

        for (int k = 0; k < 32; k++)    poke(k, pat(k));
        for (int k = 240; k < 320; k++) poke(k, pat(k));
        poke(5, 32'h2801_000a);
        poke(20, 32'h0000_0011);

        // Reset state
        chk("rst_outputs", {i_ack, d_ack, d_err, mem_en, mem_we, busy}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single fetch from word 5
        i_req = 1; i_addr = 10'd5;
        run_round();
        chk("fetch_owner", last_gi, 1);
        chk("fetch_rdata", i_rdata, 32'h2801_000a);

        // Store then load at 300
        d_req = 1; d_we = 1; d_addr = 10'd300; d_wdata = 32'hDEAD_BEEF;
        run_round();
        d_req = 1; d_we = 0; d_addr = 10'd300;
        run_round();
        chk("load_300", d_rdata, 32'hDEAD_BEEF);

        // Contention: both held high, expected order D,D,D,D,I,D,D,D,D,I
        exp_pat = 10'b10_0001_0000;
        for (int k = 0; k < 10; k++) begin
            if (!i_req) begin i_req = 1; i_addr = AW'($urandom_range(0, 31)); end
            if (!d_req) begin d_req = 1; d_we = 0; d_addr = rand_daddr(); end
            run_round();
            chk("contention_order", last_gi, exp_pat[k]);
        end
        i_req = 0; d_req = 0;
        @(posedge clk); @(negedge clk);

        // Reset during ISSUE of a store to 20
        d_req = 1; d_we = 1; d_addr = 10'd20; d_wdata = 32'h0000_0099;
        @(posedge clk); #1;
        chk("abort_issue_en", {mem_en, mem_we}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_en", {mem_en, mem_we}, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        d_req = 0;
        @(posedge clk); #1;
        chk("abort_no_ack", {d_ack, i_ack}, 0);
        chk("abort_mem20", mem[20], 32'h0000_0011);
        @(negedge clk);
        rst = 1'b0;
        sc = 0; exp_i = '0; exp_d = '0;
        chk("abort_rdata_cleared", {i_rdata, d_rdata}, 0);

        // Store into and just above the instruction region
        d_req = 1; d_we = 1; d_addr = 10'd10; d_wdata = 32'h0000_0055;
        run_round();
        chk("store10_mem", mem[10], model_mem[10]);
        d_req = 1; d_we = 1; d_addr = 10'd256; d_wdata = 32'h0000_0055;
        run_round();
        chk("store256_mem", mem[256], 32'h0000_0055);

        // Randomized traffic
        for (int r = 0; r < 120; r++) begin
            if (!i_req && $urandom_range(0, 2) != 0) begin
                i_req = 1; i_addr = AW'($urandom_range(0, 31));
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1; d_we = $urandom_range(0, 1) == 1;
                d_addr = rand_daddr(); d_wdata = $urandom;
            end
            run_round();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
